// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//   Conditions raw asynchronous push-buttons for the pong top level. Each
//   channel has a 2-FF synchronizer, a counter-based debouncer (4-state FSM)
//   and registered single-cycle press/release strobes. The debounced levels
//   feed the paddle up/down inputs; the strobes serve serve/reset logic.
//
//   Optional feature: define BTN_AUTOREPEAT_EN to add a per-channel repeat
//   counter that pulses btn_rpt RPT_DELAY cycles after a press and every
//   RPT_PERIOD cycles after that while held. Without the macro btn_rpt is
//   tied to 0 and no repeat logic exists.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   btn_raw    in   N_BTN  raw buttons, asynchronous, active-high
//   btn_level  out  N_BTN  debounced level (registered)
//   btn_press  out  N_BTN  1-cycle strobe on accepted 0->1
//   btn_rel    out  N_BTN  1-cycle strobe on accepted 1->0
//   btn_rpt    out  N_BTN  1-cycle repeat strobe while held (autorepeat only)
// -----------------------------------------------------------------------------
module btn_conditioner #(
  parameter int N_BTN      = 4,
  parameter int DB_CYCLES  = 250000,
  parameter int CNT_W      = 18,
  parameter int RPT_DELAY  = 25000000,
  parameter int RPT_PERIOD = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_rel,
  output logic [N_BTN-1:0] btn_rpt
);

  typedef enum logic [1:0] {LOW, RISE, HIGH, FALL} db_state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [N_BTN-1:0] s0, s1;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value; blocking here would collapse s0/s1 into one stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0 <= '0;
      s1 <= '0;
    end else begin
      s0 <= btn_raw;
      s1 <= s0;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    db_state_t        state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             level_q, press_q, rel_q;
    logic             level_nx, press_nx, rel_nx;

    always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case leaves a signal unassigned and no latch is inferred.
      state_nx = state;
      cnt_nx   = cnt;
      press_nx = 1'b0;
      rel_nx   = 1'b0;
      unique case (state)
        LOW: if (s1[i]) begin
          // With a one-cycle debounce window the first high sample is enough.
          if (DB_CYCLES <= 1) begin
            state_nx = HIGH;
            press_nx = 1'b1;
            cnt_nx   = '0;
          end else begin
            state_nx = RISE;
            cnt_nx   = CNT_W'(1);
          end
        end
        RISE: begin
          if (!s1[i]) begin
            state_nx = LOW;
            cnt_nx   = '0;
          end else if (cnt >= CNT_LAST) begin
            state_nx = HIGH;
            press_nx = 1'b1;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        HIGH: if (!s1[i]) begin
          if (DB_CYCLES <= 1) begin
            state_nx = LOW;
            rel_nx   = 1'b1;
            cnt_nx   = '0;
          end else begin
            state_nx = FALL;
            cnt_nx   = CNT_W'(1);
          end
        end
        FALL: begin
          if (s1[i]) begin
            state_nx = HIGH;
            cnt_nx   = '0;
          end else if (cnt >= CNT_LAST) begin
            state_nx = LOW;
            rel_nx   = 1'b1;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          state_nx = LOW;
          cnt_nx   = '0;
        end
      endcase
      level_nx = (state_nx == HIGH) || (state_nx == FALL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state   <= LOW;
        cnt     <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state   <= state_nx;
        cnt     <= cnt_nx;
        level_q <= level_nx;
        press_q <= press_nx;
        rel_q   <= rel_nx;
      end
    end

    assign btn_level[i] = level_q;
    assign btn_press[i] = press_q;
    assign btn_rel[i]   = rel_q;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(RPT_DELAY + 1);
    localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(RPT_DELAY - 1);
    // After a repeat the counter restarts so that it reaches RPT_DELAY
    // again exactly RPT_PERIOD cycles later.
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(RPT_DELAY - RPT_PERIOD);

    logic [RPT_W-1:0] rcnt;
    logic             rpt_q;
    logic             held;

    assign held = (state == HIGH) || (state == FALL);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rcnt  <= '0;
        rpt_q <= 1'b0;
      end else begin
        rpt_q <= 1'b0;
        if (!held) begin
          rcnt <= '0;
        end else if (rcnt == RPT_LAST) begin
          rcnt  <= RPT_RELOAD;
          // A release accepted on this edge suppresses the repeat.
          rpt_q <= !rel_nx;
        end else begin
          rcnt <= rcnt + 1'b1;
        end
      end
    end

    assign btn_rpt[i] = rpt_q;
`endif
  end

`ifndef BTN_AUTOREPEAT_EN
  // Constant zero; the repeat parameters only appear in a folded term.
  assign btn_rpt = {N_BTN{1'b0}} & {N_BTN{(RPT_DELAY > 0) && (RPT_PERIOD > 0)}};
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
//   Directed bench for btn_conditioner with DB_CYCLES=8, RPT_DELAY=40,
//   RPT_PERIOD=10. Inputs change 1 time unit after a rising edge and outputs
//   are checked at the same point, so a raw edge applied after edge E0 shows
//   on btn_level after edge E10.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_raw;
  logic [3:0] btn_level, btn_press, btn_rel, btn_rpt;

  int n_checks = 0;
  int n_fail   = 0;

  btn_conditioner #(
    .N_BTN      (4),
    .DB_CYCLES  (8),
    .CNT_W      (4),
    .RPT_DELAY  (40),
    .RPT_PERIOD (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_press (btn_press),
    .btn_rel   (btn_rel),
    .btn_rpt   (btn_rpt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] sticky;
    logic [3:0] exp_rpt;

    // ---- 1: reset with all buttons held ----
    rst_n   = 1'b0;
    btn_raw = 4'hF;
    step(3);
    check("t1_rst_level", btn_level, 4'h0);
    check("t1_rst_strobe", btn_press | btn_rel | btn_rpt, 4'h0);
    rst_n = 1'b1;
    #1;
    check("t1_rel_level", btn_level, 4'h0);
    check("t1_rel_press", btn_press, 4'h0);
    step(9);
    check("t1_c9_level", btn_level, 4'h0);
    check("t1_c9_press", btn_press, 4'h0);
    step(1);
    check("t1_c10_level", btn_level, 4'hF);
    check("t1_c10_press", btn_press, 4'hF);
    step(1);
    check("t1_c11_press", btn_press, 4'h0);
    btn_raw = 4'h0;
    step(9);
    check("t1_fall_c9_level", btn_level, 4'hF);
    step(1);
    check("t1_fall_level", btn_level, 4'h0);
    check("t1_fall_rel", btn_rel, 4'hF);
    step(1);
    check("t1_fall_rel_end", btn_rel, 4'h0);

    // ---- 2: clean press/release on channel 0 ----
    btn_raw = 4'b0001;
    step(9);
    check("t2_c9_level", btn_level, 4'h0);
    step(1);
    check("t2_press", btn_press, 4'b0001);
    check("t2_level", btn_level, 4'b0001);
    step(1);
    check("t2_press_end", btn_press, 4'h0);
    step(19);
    btn_raw = 4'b0000;
    step(9);
    check("t2_hold_level", btn_level, 4'b0001);
    check("t2_hold_rel", btn_rel, 4'h0);
    step(1);
    check("t2_rel", btn_rel, 4'b0001);
    check("t2_rel_level", btn_level, 4'h0);
    step(1);
    check("t2_rel_end", btn_rel, 4'h0);

    // ---- 3: bounce on channel 1, 3-cycle segments, then settle high ----
    sticky = 4'h0;
    for (int seg = 0; seg < 14; seg++) begin
      btn_raw[1] = (seg % 2 == 0);
      for (int c = 0; c < 3; c++) begin
        step(1);
        sticky |= (btn_press | btn_rel | btn_level) & 4'b0010;
      end
    end
    check("t3_bounce_quiet", sticky, 4'h0);
    btn_raw[1] = 1'b1;
    step(9);
    check("t3_c9_press", btn_press, 4'h0);
    step(1);
    check("t3_press", btn_press, 4'b0010);
    check("t3_level", btn_level, 4'b0010);
    step(1);
    check("t3_press_end", btn_press, 4'h0);
    btn_raw[1] = 1'b0;
    step(12);
    check("t3_released", btn_level, 4'h0);

    // ---- 4: channels 2 and 3 rise together, channel 3 drops after 5 ----
    btn_raw = 4'b1100;
    step(5);
    btn_raw[3] = 1'b0;
    step(4);
    check("t4_c9_press", btn_press, 4'h0);
    step(1);
    check("t4_press", btn_press, 4'b0100);
    check("t4_level", btn_level, 4'b0100);
    sticky = 4'h0;
    for (int c = 0; c < 15; c++) begin
      step(1);
      sticky |= ((btn_press | btn_rel | btn_level) & 4'b1000) | (btn_press & 4'b0100);
    end
    check("t4_ch3_quiet", sticky, 4'h0);
    check("t4_ch2_held", btn_level, 4'b0100);

    // ---- 5: reset while channel 0 is in RISE at cnt=5, channel 2 HIGH ----
    btn_raw = 4'b0101;
    step(7);
    rst_n = 1'b0;
    #1;
    check("t5_rst_level", btn_level, 4'h0);
    check("t5_rst_strobe", btn_press | btn_rel, 4'h0);
    step(2);
    rst_n = 1'b1;
    step(9);
    check("t5_c9_press", btn_press, 4'h0);
    check("t5_c9_level", btn_level, 4'h0);
    step(1);
    check("t5_press", btn_press, 4'b0101);
    check("t5_level", btn_level, 4'b0101);
    btn_raw = 4'b0000;
    step(12);
    check("t5_released", btn_level, 4'h0);

    // ---- 6: autorepeat on channel 0, raw dropped 100 cycles after press ----
    btn_raw = 4'b0001;
    step(10);
    check("t6_press", btn_press, 4'b0001);
    for (int k = 1; k <= 115; k++) begin
      step(1);
      exp_rpt = 4'h0;
`ifdef BTN_AUTOREPEAT_EN
      // The repeat due at +110 coincides with the release and is dropped.
      if (k >= 40 && k <= 100 && k % 10 == 0) exp_rpt = 4'b0001;
`endif
      check($sformatf("t6_rpt_k%0d", k), btn_rpt, exp_rpt);
      if (k == 100) btn_raw = 4'b0000;
      if (k == 110) check("t6_rel", btn_rel, 4'b0001);
    end
    check("t6_final_level", btn_level, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
